// File: rtl/core_exu_adder_arb.sv
// Shares the EXU adder between ALU issue (port 0) and LSU agen (port 1).
// Ports: two valid/ready requesters in, adder operands out, adder result in,
// one-entry registered result (data, {lt,ltu,neq}, src, tag, err) out.
module core_exu_adder_arb #(
  parameter int TAG_W      = 4,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [6:0]       in0_opcode,
  input  logic [5:0]       in0_op_type,
  input  logic [31:0]      in0_rs1,
  input  logic [31:0]      in0_rs2,
  input  logic [31:0]      in0_imme,
  input  logic [TAG_W-1:0] in0_tag,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [6:0]       in1_opcode,
  input  logic [5:0]       in1_op_type,
  input  logic [31:0]      in1_rs1,
  input  logic [31:0]      in1_rs2,
  input  logic [31:0]      in1_imme,
  input  logic [TAG_W-1:0] in1_tag,
  output logic [6:0]       add_opcode,
  output logic [5:0]       add_op_type,
  output logic [31:0]      add_rs1,
  output logic [31:0]      add_rs2,
  output logic [31:0]      add_imme,
  input  logic             add_res_valid,
  input  logic [31:0]      add_res,
  input  logic             add_lt,
  input  logic             add_ltu,
  input  logic             add_neq,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [2:0]       res_flags,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       rr_ptr;
  logic [3:0] starve_cnt;
  logic       grant0;
  logic       grant1;
  logic       slot_free;
  logic       accept_ok;
  logic       acc0;
  logic       acc1;

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free = !res_valid || res_ready;
  assign accept_ok = slot_free && !flush && !rst;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (in0_valid && in1_valid) begin
      if (PRIO_MODE == 0) begin
        grant1 = rr_ptr;
      end else begin
        grant1 = (starve_cnt == STARVE_LIM);
      end
      grant0 = !grant1;
    end else begin
      grant0 = in0_valid;
      grant1 = in1_valid;
    end
  end

  assign in0_ready = grant0 && accept_ok;
  assign in1_ready = grant1 && accept_ok;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  // With no grant the port 0 fields pass through; nothing is captured then.
  assign add_opcode  = grant1 ? in1_opcode  : in0_opcode;
  assign add_op_type = grant1 ? in1_op_type : in0_op_type;
  assign add_rs1     = grant1 ? in1_rs1     : in0_rs1;
  assign add_rs2     = grant1 ? in1_rs2     : in0_rs2;
  assign add_imme    = grant1 ? in1_imme    : in0_imme;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flags  <= '0;
      res_src    <= 1'b0;
      res_tag    <= '0;
      res_err    <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else if (flush) begin
      res_valid  <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (acc0 || acc1) begin
        res_valid <= 1'b1;
        res_data  <= add_res;
        res_flags <= {add_lt, add_ltu, add_neq};
        res_src   <= acc1;
        res_tag   <= acc1 ? in1_tag : in0_tag;
        res_err   <= !add_res_valid;
        // Pointer favours the port that did not just win.
        rr_ptr    <= acc0;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (!in1_valid || acc1) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_exu_adder_arb.sv
// Bench for core_exu_adder_arb: round-robin instance with a scoreboard,
// plus a fixed-priority instance (STARVE_MAX=3) for the starvation override.
module tb_core_exu_adder_arb;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  f;
    logic        s;
    logic [3:0]  t;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, res_ready;
  logic v0, v1, fv0, fv1;
  logic [6:0]  op0, op1;
  logic [5:0]  ty0, ty1;
  logic [31:0] rs1_0, rs2_0, imm_0, rs1_1, rs2_1, imm_1;
  logic [3:0]  tag0, tag1;

  logic r0, r1, fr0, fr1;
  logic [6:0]  rr_aop, fp_aop;
  logic [5:0]  rr_aty, fp_aty;
  logic [31:0] rr_ars1, rr_ars2, rr_aimm, fp_ars1, fp_ars2, fp_aimm;
  logic        rr_avld, rr_alt, rr_altu, rr_aneq;
  logic        fp_avld, fp_alt, fp_altu, fp_aneq;
  logic [31:0] rr_ares, fp_ares;
  logic        rr_vld, rr_src, rr_err, fp_vld, fp_src, fp_err;
  logic [31:0] rr_data, fp_data;
  logic [2:0]  rr_flags, fp_flags;
  logic [3:0]  rr_tag, fp_tag;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  logic [1:0] hist[$];

  // Stand-in adder: {valid, lt, ltu, neq, result}
  function automatic logic [35:0] addm(input logic [5:0] t,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    logic lt, ltu, neq, ok;
    logic [31:0] r;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    neq = a != b;
    ok  = 1'b1;
    case (t)
      6'd0: r = a + imm;
      6'd1: r = a + b;
      6'd2: r = a - b;
      6'd3: r = {31'b0, lt};
      default: begin r = '0; ok = 1'b0; end
    endcase
    return {ok, lt, ltu, neq, r};
  endfunction

  function automatic exp_t mk(input logic [5:0] t, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] imm, input logic s,
      input logic [3:0] tg);
    logic [35:0] m;
    exp_t x;
    m   = addm(t, a, b, imm);
    x.d = m[31:0];
    x.f = m[34:32];
    x.s = s;
    x.t = tg;
    x.e = !m[35];
    return x;
  endfunction

  assign {rr_avld, rr_alt, rr_altu, rr_aneq, rr_ares} =
    addm(rr_aty, rr_ars1, rr_ars2, rr_aimm);
  assign {fp_avld, fp_alt, fp_altu, fp_aneq, fp_ares} =
    addm(fp_aty, fp_ars1, fp_ars2, fp_aimm);

  core_exu_adder_arb #(.TAG_W(4), .PRIO_MODE(0), .STARVE_MAX(7)) u_rr (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(v0), .in0_ready(r0), .in0_opcode(op0), .in0_op_type(ty0),
    .in0_rs1(rs1_0), .in0_rs2(rs2_0), .in0_imme(imm_0), .in0_tag(tag0),
    .in1_valid(v1), .in1_ready(r1), .in1_opcode(op1), .in1_op_type(ty1),
    .in1_rs1(rs1_1), .in1_rs2(rs2_1), .in1_imme(imm_1), .in1_tag(tag1),
    .add_opcode(rr_aop), .add_op_type(rr_aty), .add_rs1(rr_ars1),
    .add_rs2(rr_ars2), .add_imme(rr_aimm), .add_res_valid(rr_avld),
    .add_res(rr_ares), .add_lt(rr_alt), .add_ltu(rr_altu), .add_neq(rr_aneq),
    .res_valid(rr_vld), .res_ready(res_ready), .res_data(rr_data),
    .res_flags(rr_flags), .res_src(rr_src), .res_tag(rr_tag), .res_err(rr_err)
  );

  core_exu_adder_arb #(.TAG_W(4), .PRIO_MODE(1), .STARVE_MAX(3)) u_fp (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(fv0), .in0_ready(fr0), .in0_opcode(op0), .in0_op_type(ty0),
    .in0_rs1(rs1_0), .in0_rs2(rs2_0), .in0_imme(imm_0), .in0_tag(tag0),
    .in1_valid(fv1), .in1_ready(fr1), .in1_opcode(op1), .in1_op_type(ty1),
    .in1_rs1(rs1_1), .in1_rs2(rs2_1), .in1_imme(imm_1), .in1_tag(tag1),
    .add_opcode(fp_aop), .add_op_type(fp_aty), .add_rs1(fp_ars1),
    .add_rs2(fp_ars2), .add_imme(fp_aimm), .add_res_valid(fp_avld),
    .add_res(fp_ares), .add_lt(fp_alt), .add_ltu(fp_altu), .add_neq(fp_aneq),
    .res_valid(fp_vld), .res_ready(res_ready), .res_data(fp_data),
    .res_flags(fp_flags), .res_src(fp_src), .res_tag(fp_tag), .res_err(fp_err)
  );

  task automatic check(input string name, input logic [31:0] obs,
      input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic new0();
    op0   = 7'h33;
    ty0   = 6'($urandom_range(0, 3));
    rs1_0 = $urandom;
    rs2_0 = $urandom;
    imm_0 = $urandom;
    tag0  = tag0 + 4'd1;
  endtask

  task automatic new1();
    op1   = 7'h03;
    ty1   = 6'($urandom_range(0, 3));
    rs1_1 = $urandom;
    rs2_1 = $urandom;
    imm_1 = $urandom;
    tag1  = tag1 + 4'd1;
  endtask

  task automatic run(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
      hist.push_back({a1, a0});
      @(posedge clk); #1;
      if (a0) new0();
      if (a1) new1();
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: push on accept, pop on drain.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      check("ready_onehot", 32'(r0 & r1), 32'd0);
      if (rr_vld && res_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_data", rr_data, e.d);
          check("sb_flags", 32'(rr_flags), 32'(e.f));
          check("sb_src", 32'(rr_src), 32'(e.s));
          check("sb_tag", 32'(rr_tag), 32'(e.t));
          check("sb_err", 32'(rr_err), 32'(e.e));
        end
      end
      if (v0 && r0) sb.push_back(mk(ty0, rs1_0, rs2_0, imm_0, 1'b0, tag0));
      if (v1 && r1) sb.push_back(mk(ty1, rs1_1, rs2_1, imm_1, 1'b1, tag1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        g1;
    logic        pg1;
    exp_t        ex0, ex1;
    tag0 = '0; tag1 = '0;
    new0(); new1();
    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    v0 = 1'b1; v1 = 1'b1; fv0 = 1'b0; fv1 = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_ready0", 32'(r0), 32'd0);
    check("rst_ready1", 32'(r1), 32'd0);
    check("rst_valid", 32'(rr_vld), 32'd0);
    check("rst_data", rr_data, 32'd0);
    check("rst_flags", 32'(rr_flags), 32'd0);
    check("rst_src_tag_err", 32'({rr_src, rr_tag, rr_err}), 32'd0);
    tick();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    tick();

    // Port 0 alone: addi 5+3
    op0 = 7'h13; ty0 = 6'd0; rs1_0 = 32'd5; rs2_0 = 32'd0; imm_0 = 32'd3;
    v0 = 1'b1;
    @(negedge clk);
    check("t1_ready0", 32'(r0), 32'd1);
    check("t1_opcode", 32'(rr_aop), 32'h13);
    check("t1_not_early", 32'(rr_vld), 32'd0);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(rr_vld), 32'd1);
    check("t1_data", rr_data, 32'd8);
    check("t1_src", 32'(rr_src), 32'd0);
    tick();

    // Round-robin alternation from a cleared pointer
    flush = 1'b1;
    tick();
    flush = 1'b0;
    new0(); new1();
    v0 = 1'b1; v1 = 1'b1;
    hist.delete();
    run(6);
    for (int i = 0; i < 6; i++)
      check("t2_alt", 32'(hist[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Backpressure for 5 cycles
    res_ready = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held = rr_data;
      check("t4_valid", 32'(rr_vld), 32'd1);
      check("t4_noready", 32'(r0 | r1), 32'd0);
      if (i > 0) check("t4_stable", rr_data, held);
      tick();
    end
    res_ready = 1'b1;
    hist.delete();
    run(2);
    check("t4_resume", 32'(hist[0] != 2'b00), 32'd1);
    v0 = 1'b0; v1 = 1'b0;
    run(2);

    // slt with signed/unsigned disagreement
    ty0 = 6'd3; rs1_0 = 32'hFFFF_FFFF; rs2_0 = 32'd1; imm_0 = 32'd0;
    v0 = 1'b1;
    @(negedge clk);
    check("t5_ready0", 32'(r0), 32'd1);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    check("t5_data", rr_data, 32'd1);
    check("t5_lt", 32'(rr_flags[2]), 32'd1);
    check("t5_ltu", 32'(rr_flags[1]), 32'd0);
    check("t5_neq", 32'(rr_flags[0]), 32'd1);
    tick();

    // Non-adder op on port 1 is still delivered, flagged as error
    ty1 = 6'd9; v1 = 1'b1;
    @(negedge clk);
    check("err_ready1", 32'(r1), 32'd1);
    tick();
    v1 = 1'b0;
    @(negedge clk);
    check("err_flag", 32'(rr_err), 32'd1);
    check("err_src", 32'(rr_src), 32'd1);
    tick();

    // Flush with a held result and both requesters valid
    res_ready = 1'b0;
    new0(); new1();
    v0 = 1'b1;
    @(negedge clk);
    check("t6_ready0", 32'(r0), 32'd1);
    tick();
    new0();
    v1 = 1'b1;
    @(negedge clk);
    check("t6_held", 32'(rr_vld), 32'd1);
    check("t6_blocked", 32'(r0 | r1), 32'd0);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("t6_flush_noready", 32'(r0 | r1), 32'd0);
    tick();
    flush = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("t6_dropped", 32'(rr_vld), 32'd0);
    check("t6_ptr0", 32'({r1, r0}), 32'd1);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    run(2);

    // Fixed priority with starvation override every 4th cycle
    ty0 = 6'd1; rs1_0 = 32'd100; rs2_0 = 32'd20; imm_0 = 32'd0; op0 = 7'h33;
    ty1 = 6'd2; rs1_1 = 32'd7; rs2_1 = 32'd9; imm_1 = 32'd0; op1 = 7'h23;
    ex0 = mk(ty0, rs1_0, rs2_0, imm_0, 1'b0, tag0);
    ex1 = mk(ty1, rs1_1, rs2_1, imm_1, 1'b1, tag1);
    fv0 = 1'b1; fv1 = 1'b1;
    pg1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g1 = (i % 4 == 3);
      check("t3_ready1", 32'(fr1), 32'(g1));
      check("t3_ready0", 32'(fr0), 32'(!g1));
      check("t3_aop", 32'(fp_aop), g1 ? 32'h23 : 32'h33);
      if (i > 0) begin
        check("t3_valid", 32'(fp_vld), 32'd1);
        check("t3_src", 32'(fp_src), 32'(pg1));
        check("t3_data", fp_data, pg1 ? ex1.d : ex0.d);
        check("t3_flags", 32'(fp_flags), 32'(pg1 ? ex1.f : ex0.f));
        check("t3_tag", 32'(fp_tag), 32'(pg1 ? ex1.t : ex0.t));
        check("t3_err", 32'(fp_err), 32'd0);
      end
      pg1 = g1;
      tick();
    end
    fv0 = 1'b0; fv1 = 1'b1;
    fv1 = 1'b0;
    run(2);

    // Reset while a result is held
    res_ready = 1'b0;
    new0();
    v0 = 1'b1;
    @(negedge clk);
    check("rm_ready0", 32'(r0), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rm_noready", 32'(r0 | r1), 32'd0);
    tick();
    rst = 1'b0; v0 = 1'b0;
    @(negedge clk);
    check("rm_valid", 32'(rr_vld), 32'd0);
    check("rm_data", rr_data, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
